// File: rtl/rs_latch_bank_ctrl_pkg.sv
// Shared types and constants for the gated RS latch bank sequencer.
package rs_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ENABLE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_CLR   = 1'b0;
    localparam logic REQ_ID_A = 1'b0;
    localparam logic REQ_ID_B = 1'b1;

    // Phase counter runs 0..max(PULSE_W, HOLD_W)-1.
    function automatic int cnt_width(input int pulse_w, input int hold_w);
        int m;
        m = (pulse_w > hold_w) ? pulse_w : hold_w;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rs_latch_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; priority flips away from whoever was last served.
module rr_arb2
    import rs_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_done,
    input  logic i_served,
    output logic o_valid,
    output logic o_winner
);

    logic r_prio;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio <= REQ_ID_A;
        end else if (i_done) begin
            r_prio <= ~i_served;
        end
    end

    always_comb begin
        o_valid  = i_req_a | i_req_b;
        o_winner = REQ_ID_A;
        if (i_req_a && i_req_b) begin
            o_winner = r_prio;
        end else if (i_req_b) begin
            o_winner = REQ_ID_B;
        end
    end

endmodule

// File: rtl/rs_latch_bank_ctrl.sv
// Sequences set/clear commands from two requesters onto a bank of gated RS latches:
// setup -> enable pulse -> hold -> ack, never driving S and R together.
module rs_latch_bank_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = 2,
    parameter int PULSE_W = 2,
    parameter int HOLD_W  = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_A,
    input  logic          OP_A,
    input  logic [AW-1:0] ADDR_A,
    output logic          ACK_A,
    input  logic          REQ_B,
    input  logic          OP_B,
    input  logic [AW-1:0] ADDR_B,
    output logic          ACK_B,
    output logic [N-1:0]  S,
    output logic [N-1:0]  R,
    output logic [N-1:0]  E,
    output logic          BUSY,
    output logic          GRANT,
    output logic          ERR
);

    localparam int CNT_W = cnt_width(PULSE_W, HOLD_W);
    localparam int AW1   = AW + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_W - 1);
    localparam logic [AW:0]      N_LIM      = AW1'(N);
    localparam logic [N-1:0]     ONE        = N'(1);

    state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic           w_capture;
    logic           r_op, w_op_nxt;
    logic [AW-1:0]  r_addr, w_addr_nxt;
    logic           w_win_nxt;
    logic           w_arb_valid, w_arb_win;
    logic           w_in_range;
    logic [N-1:0]   w_hit;
    logic           w_drive;

    logic [N-1:0]   r_s, r_r, r_e;
    logic           r_ack_a, r_ack_b, r_busy, r_grant, r_err;

    rr_arb2 u_arb (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_req_a  (REQ_A),
        .i_req_b  (REQ_B),
        .i_done   (r_state == DONE),
        .i_served (r_grant),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_win)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = SETUP;
                    w_capture   = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt = ENABLE;
                w_cnt_nxt   = '0;
            end
            ENABLE: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        w_win_nxt  = w_capture ? w_arb_win : r_grant;
        w_op_nxt   = r_op;
        w_addr_nxt = r_addr;
        if (w_capture) begin
            w_op_nxt   = (w_arb_win == REQ_ID_B) ? OP_B : OP_A;
            w_addr_nxt = (w_arb_win == REQ_ID_B) ? ADDR_B : ADDR_A;
        end
        w_in_range = ({1'b0, w_addr_nxt} < N_LIM);
        w_hit      = w_in_range ? (ONE << w_addr_nxt) : '0;
        w_drive    = (w_state_nxt == SETUP) || (w_state_nxt == ENABLE) || (w_state_nxt == HOLD);
    end

    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_op   <= w_op_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_s     <= '0;
            r_r     <= '0;
            r_e     <= '0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_busy  <= 1'b0;
            r_grant <= REQ_ID_A;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= (w_drive && w_op_nxt == OP_SET) ? w_hit : '0;
            r_r     <= (w_drive && w_op_nxt == OP_CLR) ? w_hit : '0;
            r_e     <= (w_state_nxt == ENABLE) ? w_hit : '0;
            r_ack_a <= (w_state_nxt == DONE) && (w_win_nxt == REQ_ID_A);
            r_ack_b <= (w_state_nxt == DONE) && (w_win_nxt == REQ_ID_B);
            r_busy  <= (w_state_nxt != IDLE);
            r_grant <= w_win_nxt;
            r_err   <= (w_state_nxt == DONE) && !w_in_range;
        end
    end

    assign S     = r_s;
    assign R     = r_r;
    assign E     = r_e;
    assign ACK_A = r_ack_a;
    assign ACK_B = r_ack_b;
    assign BUSY  = r_busy;
    assign GRANT = r_grant;
    assign ERR   = r_err;

endmodule

// File: tb/tb_rs_latch_bank_ctrl.sv
// Directed bench for rs_latch_bank_ctrl with a behavioural gated-latch bank on the main instance.
module tb_rs_latch_bank_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, op_a = 1'b0, req_b = 1'b0, op_b = 1'b0;
    logic [1:0] addr_a = 2'd0, addr_b = 2'd0;
    logic       ack_a, ack_b, busy, grant, err;
    logic [3:0] s, r, e;
    logic [3:0] q = 4'b0000;

    logic       x_req_a = 1'b0, x_op_a = 1'b0, x_req_b = 1'b0, x_op_b = 1'b0;
    logic [1:0] x_addr_a = 2'd0, x_addr_b = 2'd0;
    logic       x_ack_a, x_ack_b, x_busy, x_grant, x_err;
    logic [2:0] x_s, x_r, x_e;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_latch_bank_ctrl #(.N(4), .AW(2), .PULSE_W(2), .HOLD_W(1)) u_dut (
        .CLK(clk), .RST(rst),
        .REQ_A(req_a), .OP_A(op_a), .ADDR_A(addr_a), .ACK_A(ack_a),
        .REQ_B(req_b), .OP_B(op_b), .ADDR_B(addr_b), .ACK_B(ack_b),
        .S(s), .R(r), .E(e), .BUSY(busy), .GRANT(grant), .ERR(err)
    );

    rs_latch_bank_ctrl #(.N(3), .AW(2), .PULSE_W(2), .HOLD_W(1)) u_oor (
        .CLK(clk), .RST(rst),
        .REQ_A(x_req_a), .OP_A(x_op_a), .ADDR_A(x_addr_a), .ACK_A(x_ack_a),
        .REQ_B(x_req_b), .OP_B(x_op_b), .ADDR_B(x_addr_b), .ACK_B(x_ack_b),
        .S(x_s), .R(x_r), .E(x_e), .BUSY(x_busy), .GRANT(x_grant), .ERR(x_err)
    );

    // Gated RS latch bank: transparent while E is high, S wins is impossible by construction.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
                if (s[i])      q[i] <= 1'b1;
                else if (r[i]) q[i] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("inv_sr", {28'b0, s & r}, 32'd0);
        chk("inv_e1", {31'b0, ($countones(e) > 1)}, 32'd0);
        chk("inv_esr", {28'b0, e & ~(s | r)}, 32'd0);
        chk("inv_ack", {31'b0, ack_a & ack_b}, 32'd0);
    endtask

    // One full transaction on the main instance: cycles 1..5 busy, cycle 6 idle.
    task automatic op_seq(input logic win, input int addr, input logic op, input int drop_cyc);
        logic [3:0] hit;
        hit = 4'b0001 << addr;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("c%0d_s", c), {28'b0, s}, (c <= 4 && op)  ? {28'b0, hit} : 32'd0);
            chk($sformatf("c%0d_r", c), {28'b0, r}, (c <= 4 && !op) ? {28'b0, hit} : 32'd0);
            chk($sformatf("c%0d_e", c), {28'b0, e}, (c == 2 || c == 3) ? {28'b0, hit} : 32'd0);
            chk($sformatf("c%0d_ack_a", c), {31'b0, ack_a}, (c == 5 && !win) ? 32'd1 : 32'd0);
            chk($sformatf("c%0d_ack_b", c), {31'b0, ack_b}, (c == 5 && win) ? 32'd1 : 32'd0);
            chk($sformatf("c%0d_busy", c), {31'b0, busy}, (c <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("c%0d_grant", c), {31'b0, grant}, {31'b0, win});
            chk($sformatf("c%0d_err", c), {31'b0, err}, 32'd0);
            if (c == drop_cyc) begin
                if (win) req_b = 1'b0;
                else     req_a = 1'b0;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s", {28'b0, s}, 32'd0);
        chk("rst_r", {28'b0, r}, 32'd0);
        chk("rst_e", {28'b0, e}, 32'd0);
        chk("rst_ack", {30'b0, ack_a, ack_b}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_grant", {31'b0, grant}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;

        // A sets latch 2
        req_a = 1'b1; op_a = 1'b1; addr_a = 2'd2;
        op_seq(1'b0, 2, 1'b1, 5);
        chk("t1_q2", {31'b0, q[2]}, 32'd1);

        // Contention from reset: A clears latch1, then B sets latch3
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a = 1'b1; op_a = 1'b0; addr_a = 2'd1;
        req_b = 1'b1; op_b = 1'b1; addr_b = 2'd3;
        op_seq(1'b0, 1, 1'b0, 5);
        op_seq(1'b1, 3, 1'b1, 5);
        chk("t2_q3", {31'b0, q[3]}, 32'd1);
        chk("t2_q1", {31'b0, q[1]}, 32'd0);

        // Fairness: both held for four operations
        req_a = 1'b1; op_a = 1'b1; addr_a = 2'd1;
        req_b = 1'b1; op_b = 1'b0; addr_b = 2'd2;
        op_seq(1'b0, 1, 1'b1, 0);
        op_seq(1'b1, 2, 1'b0, 0);
        op_seq(1'b0, 1, 1'b1, 0);
        req_a = 1'b0;
        op_seq(1'b1, 2, 1'b0, 5);
        chk("t3_q1", {31'b0, q[1]}, 32'd1);
        chk("t3_q2", {31'b0, q[2]}, 32'd0);

        // Early REQ drop: A pulses one cycle to set latch0
        chk("t4_q0_pre", {31'b0, q[0]}, 32'd0);
        req_a = 1'b1; op_a = 1'b1; addr_a = 2'd0;
        op_seq(1'b0, 0, 1'b1, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_idle%0d", k), {31'b0, busy}, 32'd0);
        end
        chk("t4_q0", {31'b0, q[0]}, 32'd1);

        // Reset mid-operation on a set to latch0
        req_a = 1'b1; op_a = 1'b1; addr_a = 2'd0;
        step(); step(); step();
        chk("t5_e_pre", {28'b0, e}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_s", {28'b0, s}, 32'd0);
        chk("t5_r", {28'b0, r}, 32'd0);
        chk("t5_e", {28'b0, e}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("t5_ack%0d", k), {31'b0, ack_a}, 32'd0);
            chk($sformatf("t5_busy%0d", k), {31'b0, busy}, 32'd0);
        end
        rst = 1'b0;
        op_seq(1'b0, 0, 1'b1, 5);

        // Out-of-range address on the N=3 instance
        x_req_b = 1'b1; x_op_b = 1'b1; x_addr_b = 2'd3;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("oor%0d_s", c), {29'b0, x_s}, 32'd0);
            chk($sformatf("oor%0d_r", c), {29'b0, x_r}, 32'd0);
            chk($sformatf("oor%0d_e", c), {29'b0, x_e}, 32'd0);
            chk($sformatf("oor%0d_ack_b", c), {31'b0, x_ack_b}, (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("oor%0d_ack_a", c), {31'b0, x_ack_a}, 32'd0);
            chk($sformatf("oor%0d_err", c), {31'b0, x_err}, (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("oor%0d_busy", c), {31'b0, x_busy}, (c <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("oor%0d_grant", c), {31'b0, x_grant}, 32'd1);
            if (c == 5) x_req_b = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
